// File: rtl/simd_alu_pkg.sv
// Shared lane-mode encodings, lane geometry constants and helpers for the
// SIMD adder pipeline and its per-byte saturation slices.
package simd_alu_pkg;

    localparam int BYTE_W         = 8;
    localparam int NUM_LANE_SIZES = 4;

    // Encoding of the data_mode input: lane width is 8 << mode bits.
    typedef enum logic [1:0] {
        LANE_8  = 2'd0,
        LANE_16 = 2'd1,
        LANE_32 = 2'd2,
        LANE_64 = 2'd3
    } lane_mode_e;

    // Per-beat control that must travel alongside the data from S1 to S2.
    typedef struct packed {
        lane_mode_e mode;
        logic       data_signed;
        logic       saturate;
    } beat_ctrl_t;

    // Lane width in bits for lane-size index 0..3.
    function automatic int lane_width(input int idx);
        return BYTE_W << idx;
    endfunction

    // Index of the sign bit inside a lane of size index idx.
    function automatic int lane_msb(input int idx);
        return lane_width(idx) - 1;
    endfunction

    // Mask of the low byte-slot index bits that select a byte inside a lane.
    // A slot is the top byte of its lane when all masked bits are ones.
    function automatic logic [2:0] lane_byte_mask(input lane_mode_e m);
        logic [2:0] mask;
        case (m)
            LANE_8:  mask = 3'b000;
            LANE_16: mask = 3'b001;
            LANE_32: mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/simd_lane_sat.sv
// Combinational clamp of one byte slot: picks the saturated byte for the
// slot's position in its lane, or passes the wrapped byte through.
module simd_lane_sat
    import simd_alu_pkg::*;
#(
    parameter int SLOT = 0
) (
    input  lane_mode_e  mode,
    input  logic        data_signed,
    input  logic        saturate,
    input  logic        ovf,
    input  logic        udf,
    input  logic [7:0]  raw_byte,
    output logic [7:0]  sat_byte
);

    localparam logic [2:0] SLOT_LOW = 3'(SLOT % 8);

    logic is_msb_byte;

    // Only the top byte of a signed lane carries the sign of the clamp value.
    assign is_msb_byte = &(SLOT_LOW | ~lane_byte_mask(mode));

    // Select max/min byte pattern on overflow/underflow when clamping.
    always_comb begin
        sat_byte = raw_byte;
        if (saturate) begin
            if (ovf) begin
                sat_byte = (data_signed && is_msb_byte) ? 8'h7F : 8'hFF;
            end else if (udf) begin
                sat_byte = (data_signed && is_msb_byte) ? 8'h80 : 8'h00;
            end
        end
    end

endmodule

// File: rtl/simd_alu_adder_pipe.sv
// Two-stage SIMD add/sub: S1 does carry-isolated lane arithmetic for every
// lane size and keeps the one selected by data_mode; S2 clamps per byte
// slot and presents the beat with valid/ready backpressure.
module simd_alu_adder_pipe
    import simd_alu_pkg::*;
#(
    parameter int SIMD_DATA_WIDTH            = 256,
    parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2,
    parameter int EVT_CNT_WIDTH              = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SIMD_DATA_WIDTH-1:0]            a,
    input  logic [SIMD_DATA_WIDTH-1:0]            b,
    input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] data_mode,
    input  logic                                  data_signed,
    input  logic                                  sub,
    input  logic                                  saturate,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SIMD_DATA_WIDTH-1:0]            result,
    output logic [SIMD_DATA_WIDTH/8-1:0]          ovf,
    output logic [SIMD_DATA_WIDTH/8-1:0]          udf,
    input  logic                                  evt_clr,
    output logic [EVT_CNT_WIDTH-1:0]              evt_cnt
);

    localparam int W  = SIMD_DATA_WIDTH;
    localparam int NB = SIMD_DATA_WIDTH / 8;

    // Lane results and per-byte flags for every lane size, selected below.
    logic [NUM_LANE_SIZES-1:0][W-1:0]  sum_all;
    logic [NUM_LANE_SIZES-1:0][NB-1:0] ovf_all;
    logic [NUM_LANE_SIZES-1:0][NB-1:0] udf_all;

    lane_mode_e mode_sel;
    beat_ctrl_t ctrl_in;

    // Pipeline state.
    logic              v1_reg, v1_next;
    logic [W-1:0]      sum1_reg;
    logic [NB-1:0]     ovf1_reg, udf1_reg;
    beat_ctrl_t        ctrl1_reg;
    logic              v2_reg, v2_next;
    logic [W-1:0]      result_reg;
    logic [NB-1:0]     ovf2_reg, udf2_reg;
    logic [EVT_CNT_WIDTH-1:0] evt_cnt_reg, evt_cnt_next;

    logic          load1, load2, out_xfer;
    logic [W-1:0]  sat_res;

    assign mode_sel = lane_mode_e'(data_mode[1:0]);
    assign ctrl_in  = '{mode: mode_sel, data_signed: data_signed, saturate: saturate};

    // Lane arithmetic: a + (b ^ sub) + sub inside each lane, so no carry
    // can leak across a lane boundary.
    for (genvar gi = 0; gi < NUM_LANE_SIZES; gi++) begin : g_size
        localparam int LW  = lane_width(gi);
        localparam int MSB = lane_msb(gi);
        localparam int NL  = W / LW;
        localparam int LB  = LW / 8;
        for (genvar gj = 0; gj < NL; gj++) begin : g_lane
            logic [LW-1:0] a_l, bx_l;
            logic [LW:0]   s_l;
            logic          flag_ovf, flag_udf;
            assign a_l  = a[gj*LW +: LW];
            assign bx_l = b[gj*LW +: LW] ^ {LW{sub}};
            assign s_l  = {1'b0, a_l} + {1'b0, bx_l} + {{LW{1'b0}}, sub};
            // Signed overflow only when both addends share a sign the sum lacks.
            always_comb begin
                if (data_signed) begin
                    flag_ovf = ~a_l[MSB] & ~bx_l[MSB] &  s_l[MSB];
                    flag_udf =  a_l[MSB] &  bx_l[MSB] & ~s_l[MSB];
                end else begin
                    flag_ovf = ~sub &  s_l[LW];
                    flag_udf =  sub & ~s_l[LW];
                end
            end
            assign sum_all[gi][gj*LW +: LW] = s_l[LW-1:0];
            assign ovf_all[gi][gj*LB +: LB] = {LB{flag_ovf}};
            assign udf_all[gi][gj*LB +: LB] = {LB{flag_udf}};
        end
    end

    // Per-byte saturation slices in S2.
    for (genvar gi = 0; gi < NB; gi++) begin : g_sat
        simd_lane_sat #(
            .SLOT (gi)
        ) u_sat (
            .mode        (ctrl1_reg.mode),
            .data_signed (ctrl1_reg.data_signed),
            .saturate    (ctrl1_reg.saturate),
            .ovf         (ovf1_reg[gi]),
            .udf         (udf1_reg[gi]),
            .raw_byte    (sum1_reg[gi*8 +: 8]),
            .sat_byte    (sat_res[gi*8 +: 8])
        );
    end

    assign in_ready = ~v1_reg | ~v2_reg | out_ready;
    assign load1    = in_valid & in_ready;
    assign load2    = v1_reg & (~v2_reg | out_ready);
    assign out_xfer = v2_reg & out_ready;

    // Stage occupancy and event counter next-state.
    always_comb begin
        v1_next = v1_reg;
        if (load1) begin
            v1_next = 1'b1;
        end else if (load2) begin
            v1_next = 1'b0;
        end

        v2_next = v2_reg;
        if (load2) begin
            v2_next = 1'b1;
        end else if (out_ready) begin
            v2_next = 1'b0;
        end

        evt_cnt_next = evt_cnt_reg;
        if (evt_clr) begin
            evt_cnt_next = '0;
        end else if (out_xfer && |(ovf2_reg | udf2_reg) && evt_cnt_reg != '1) begin
            evt_cnt_next = evt_cnt_reg + {{(EVT_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // S1 register: capture the mode-selected lane results and beat control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            sum1_reg  <= '0;
            ovf1_reg  <= '0;
            udf1_reg  <= '0;
            ctrl1_reg <= '0;
        end else begin
            v1_reg <= v1_next;
            if (load1) begin
                sum1_reg  <= sum_all[mode_sel];
                ovf1_reg  <= ovf_all[mode_sel];
                udf1_reg  <= udf_all[mode_sel];
                ctrl1_reg <= ctrl_in;
            end
        end
    end

    // S2 register: clamped result held stable until accepted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_reg     <= 1'b0;
            result_reg <= '0;
            ovf2_reg   <= '0;
            udf2_reg   <= '0;
        end else begin
            v2_reg <= v2_next;
            if (load2) begin
                result_reg <= sat_res;
                ovf2_reg   <= ovf1_reg;
                udf2_reg   <= udf1_reg;
            end
        end
    end

    // Count delivered beats carrying any overflow/underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt_reg <= '0;
        end else begin
            evt_cnt_reg <= evt_cnt_next;
        end
    end

    assign out_valid = v2_reg;
    assign result    = result_reg;
    assign ovf       = ovf2_reg;
    assign udf       = udf2_reg;
    assign evt_cnt   = evt_cnt_reg;

endmodule

// File: tb/tb_simd_alu_adder_pipe.sv
// Scoreboard bench for simd_alu_adder_pipe: directed vectors push expected
// beats, a negedge monitor pops and compares every delivered beat.
module tb_simd_alu_adder_pipe;

    localparam int W  = 256;
    localparam int NB = W / 8;
    localparam int MW = 2;
    localparam int EW = 4;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [NB-1:0] ovf;
        logic [NB-1:0] udf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [MW-1:0] data_mode = '0;
    logic          data_signed = 1'b0;
    logic          sub = 1'b0;
    logic          saturate = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [NB-1:0] ovf;
    logic [NB-1:0] udf;
    logic          evt_clr = 1'b0;
    logic [EW-1:0] evt_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [EW-1:0] exp_evt = '0;
    int   occ = 0;
    logic bp_en = 1'b0;
    int   bp_phase = 0;
    int   ov_seen = 0;

    localparam logic [NB-1:0] F_ALL  = {NB{1'b1}};
    localparam logic [NB-1:0] F_NONE = '0;

    always #5 clk = ~clk;

    simd_alu_adder_pipe #(
        .SIMD_DATA_WIDTH            (W),
        .SIMD_ADDER_DATA_MODE_WIDTH (MW),
        .EVT_CNT_WIDTH              (EW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .data_mode   (data_mode),
        .data_signed (data_signed),
        .sub         (sub),
        .saturate    (saturate),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .ovf         (ovf),
        .udf         (udf),
        .evt_clr     (evt_clr),
        .evt_cnt     (evt_cnt)
    );

    // Replicate a lane value of width lw across the whole vector.
    function automatic logic [W-1:0] rep(input logic [63:0] v, input int lw);
        logic [W-1:0] r;
        logic [63:0]  m;
        m = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
        r = '0;
        for (int i = 0; i < W / lw; i++) begin
            r = r | ({{(W-64){1'b0}}, v & m} << (i * lw));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Present one beat, record its expected response, wait for acceptance.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input int mode,
                        input logic sgn, input logic sb, input logic sat,
                        input logic [W-1:0] er, input logic [NB-1:0] eo, input logic [NB-1:0] eu);
        exp_t e;
        logic ok;
        int   n;
        a = va; b = vb; data_mode = MW'(mode);
        data_signed = sgn; sub = sb; saturate = sat;
        in_valid = 1'b1;
        e.res = er; e.ovf = eo; e.udf = eu;
        sb_q.push_back(e);
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: beat not accepted in %0d cycles", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats still pending, expected 0", sb_q.size());
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Downstream backpressure pattern 1,0,0 repeating when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = (bp_phase == 0);
                bp_phase  = (bp_phase + 1) % 3;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t          e;
        logic          prev_stall;
        logic [W-1:0]  prev_res;
        logic [NB-1:0] prev_ovf, prev_udf;
        logic          xin, xout, flagged;
        prev_stall = 1'b0;
        prev_res = '0; prev_ovf = '0; prev_udf = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                occ        = 0;
                exp_evt    = '0;
                prev_stall = 1'b0;
            end else begin
                if (out_valid) ov_seen++;
                checks++;
                if (in_ready !== !(occ == 2 && !out_ready)) begin
                    errors++;
                    $display("FAIL in_ready: got %b expected %b (occupancy %0d, out_ready %b)",
                             in_ready, !(occ == 2 && !out_ready), occ, out_ready);
                end
                checks++;
                if (evt_cnt !== exp_evt) begin
                    errors++;
                    $display("FAIL evt_model: got %0d expected %0d", evt_cnt, exp_evt);
                end
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || result !== prev_res || ovf !== prev_ovf || udf !== prev_udf) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b result=%h expected held %h", out_valid, result, prev_res);
                    end
                end
                xin     = in_valid && in_ready;
                xout    = out_valid && out_ready;
                flagged = 1'b0;
                if (xout) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got result %h expected no beat", result);
                    end else begin
                        e = sb_q.pop_front();
                        flagged = |(e.ovf | e.udf);
                        if (result !== e.res || ovf !== e.ovf || udf !== e.udf) begin
                            errors++;
                            $display("FAIL beat: got res=%h ovf=%h udf=%h expected res=%h ovf=%h udf=%h",
                                     result, ovf, udf, e.res, e.ovf, e.udf);
                        end else begin
                            $display("beat ok: res=%h ovf=%h udf=%h", result, ovf, udf);
                        end
                    end
                end
                if (evt_clr) begin
                    exp_evt = '0;
                end else if (flagged && exp_evt != {EW{1'b1}}) begin
                    exp_evt = exp_evt + 1'b1;
                end
                occ = occ + (xin ? 1 : 0) - (xout ? 1 : 0);
                prev_stall = out_valid && !out_ready;
                prev_res = result; prev_ovf = ovf; prev_udf = udf;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // Reset state.
        #12;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_result", result, '0);
        check("rst_ovf", W'(ovf), '0);
        check("rst_udf", W'(udf), '0);
        check("rst_evt", W'(evt_cnt), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", W'(in_ready), W'(1'b1));

        // 8b unsigned add with wrap; first beat also checks latency.
        send(rep(64'hF0, 8), rep(64'h20, 8), 0, 1'b0, 1'b0, 1'b0, rep(64'h10, 8), F_ALL, F_NONE);
        check("latency_s1", W'(out_valid), W'(1'b0));
        @(posedge clk); #1;
        check("latency_s2", W'(out_valid), W'(1'b1));
        drain();

        // 64b unsigned add saturating to all-ones; second flagged beat.
        send('1, rep(64'h1, 64), 3, 1'b0, 1'b0, 1'b1, '1, F_ALL, F_NONE);
        drain();
        check("evt_after_64b", W'(evt_cnt), W'(4'd2));

        // Directed lane vectors, back to back.
        send(rep(64'h8000, 16), rep(64'h0001, 16), 1, 1'b1, 1'b1, 1'b1, rep(64'h8000, 16), F_NONE, F_ALL);
        send(rep(64'h8000, 16), rep(64'h0001, 16), 1, 1'b1, 1'b1, 1'b0, rep(64'h7FFF, 16), F_NONE, F_ALL);
        send(rep(64'h10, 8), rep(64'h20, 8), 0, 1'b0, 1'b1, 1'b1, rep(64'h00, 8), F_NONE, F_ALL);
        send(rep(64'h7FFFFFFF, 32), rep(64'h1, 32), 2, 1'b1, 1'b0, 1'b1, rep(64'h7FFFFFFF, 32), F_ALL, F_NONE);
        send(rep(64'h7FFFFFFF, 32), rep(64'h1, 32), 2, 1'b1, 1'b0, 1'b0, rep(64'h80000000, 32), F_ALL, F_NONE);
        send(rep(64'h1234, 16), rep(64'h1111, 16), 1, 1'b0, 1'b0, 1'b1, rep(64'h2345, 16), F_NONE, F_NONE);
        send(rep(64'h80, 8), rep(64'hFF, 8), 0, 1'b1, 1'b0, 1'b1, rep(64'h80, 8), F_NONE, F_ALL);
        send(rep(64'h00FF, 16), rep(64'h0001, 16), 0, 1'b0, 1'b0, 1'b0, rep(64'h0000, 16), 32'h5555_5555, F_NONE);
        send(rep(64'h00FF, 16), rep(64'h0001, 16), 1, 1'b0, 1'b0, 1'b0, rep(64'h0100, 16), F_NONE, F_NONE);
        send(rep(64'h5, 32), rep(64'h3, 32), 2, 1'b0, 1'b1, 1'b1, rep(64'h2, 32), F_NONE, F_NONE);
        send(rep(64'h7F, 8), rep(64'hFF, 8), 0, 1'b1, 1'b1, 1'b1, rep(64'h7F, 8), F_ALL, F_NONE);
        send(rep(64'h8000000000000000, 64), rep(64'h8000000000000000, 64), 3, 1'b1, 1'b0, 1'b0,
             '0, F_NONE, F_ALL);
        drain();

        // Eight beats under 1,0,0 backpressure.
        bp_phase = 0;
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(rep(64'(8'h10 * i), 8), rep(64'h05, 8), 0, 1'b0, 1'b0, 1'b0,
                 rep(64'(8'h10 * i + 8'h05), 8), F_NONE, F_NONE);
        end
        drain();
        bp_en = 1'b0;
        out_ready = 1'b1;

        // Event counter saturation.
        for (int i = 0; i < 16; i++) begin
            send(rep(64'hF0, 8), rep(64'h20, 8), 0, 1'b0, 1'b0, 1'b0, rep(64'h10, 8), F_ALL, F_NONE);
        end
        drain();
        check("evt_saturated", W'(evt_cnt), W'(4'hF));

        // Clear coincident with a flagged delivery.
        send(rep(64'hF0, 8), rep(64'h20, 8), 0, 1'b0, 1'b0, 1'b0, rep(64'h10, 8), F_ALL, F_NONE);
        @(posedge clk); #1;
        check("clr_beat_present", W'(out_valid), W'(1'b1));
        evt_clr = 1'b1;
        @(posedge clk); #1;
        evt_clr = 1'b0;
        check("evt_clr_priority", W'(evt_cnt), '0);
        drain();

        // One flagged beat so the counter is nonzero, then reset mid-flight.
        send(rep(64'hF0, 8), rep(64'h20, 8), 0, 1'b0, 1'b0, 1'b0, rep(64'h10, 8), F_ALL, F_NONE);
        drain();
        check("evt_before_reset", W'(evt_cnt), W'(4'd1));
        out_ready = 1'b0;
        send(rep(64'h01, 8), rep(64'h01, 8), 0, 1'b0, 1'b0, 1'b0, rep(64'h02, 8), F_NONE, F_NONE);
        send(rep(64'h02, 8), rep(64'h01, 8), 0, 1'b0, 1'b0, 1'b0, rep(64'h03, 8), F_NONE, F_NONE);
        check("inflight_valid", W'(out_valid), W'(1'b1));
        rst_n = 1'b0;
        #1;
        check("reset_kills_valid", W'(out_valid), W'(1'b0));
        check("reset_clears_evt", W'(evt_cnt), '0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = ov_seen;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("no_stale_beat", W'(ov_seen - cnt), '0);
        check("in_ready_after_midreset", W'(in_ready), W'(1'b1));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_alu_adder_pipe.md
SIMD_ALU_ADDER_PIPE -- requirements
Module: simd_alu_adder_pipe

Interface
REQ-001 SHALL have parameter SIMD_DATA_WIDTH, default 256: vector width in bits; multiple of 64.
REQ-002 SHALL have parameter SIMD_ADDER_DATA_MODE_WIDTH, default 2: data_mode width.
REQ-003 SHALL have parameter EVT_CNT_WIDTH, default 16: event counter width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 a, b  input  SIMD_DATA_WIDTH each  operand vectors.
REQ-009 data_mode  input  SIMD_ADDER_DATA_MODE_WIDTH  lane size: 0=8b, 1=16b, 2=32b, 3=64b.
REQ-010 data_signed  input  1  two's complement lanes when 1.
REQ-011 sub  input  1  a-b when 1, a+b when 0.
REQ-012 saturate  input  1  clamp lanes on overflow/underflow when 1, wrap when 0.
REQ-013 out_valid  output  1  result beat valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 result  output  SIMD_DATA_WIDTH  lane results.
REQ-016 ovf, udf  output  SIMD_DATA_WIDTH/8 each  per-byte-slot overflow/underflow flags.
REQ-017 evt_clr  input  1  synchronous clear of evt_cnt.
REQ-018 evt_cnt  output  EVT_CNT_WIDTH  count of delivered beats with any ovf/udf bit set.

Function
REQ-019 Transfer in SHALL occur when in_valid&in_ready; transfer out when out_valid&out_ready.
REQ-020 Pipeline SHALL be two stages (S1 arithmetic, S2 saturation/output); latency in-transfer to out_valid SHALL be exactly 2 cycles with out_ready held 1.
REQ-021 Each stage SHALL load when empty or when the next stage loads/drains; in_ready = ~v1 | (~v2 | out_ready); full throughput of 1 beat/cycle with out_ready=1.
REQ-022 result/ovf/udf SHALL hold stable while out_valid=1 and out_ready=0; no beat SHALL be lost or duplicated.
REQ-023 Control fields (data_mode, data_signed, sub, saturate) SHALL be captured per beat and travel with it.
REQ-024 Lane arithmetic: sub computes a + ~b + 1 per lane; no carry SHALL cross a lane boundary.
REQ-025 Unsigned: carry-out on add sets ovf; borrow (a<b) on sub sets udf.
REQ-026 Signed: result exceeding lane max sets ovf; below lane min sets udf; ovf and udf never both set in one lane.
REQ-027 Lane flag SHALL be replicated onto every byte slot of the lane (e.g. 32b lane k drives bits 4k..4k+3).
REQ-028 saturate=1: ovf lanes SHALL yield max (unsigned all-ones, signed 0x7F..F), udf lanes SHALL yield min (unsigned 0, signed 0x80..0); flags still reported.
REQ-029 saturate=0: wrapped modulo-2^L result; flags still reported.
REQ-030 evt_cnt SHALL increment once per out-transfer with |(ovf|udf) and SHALL saturate at all-ones; evt_clr takes priority over a simultaneous increment.

Reset
REQ-031 rst_n low SHALL asynchronously clear v1, v2, out_valid, evt_cnt, result, ovf, udf to 0; in_ready SHALL be 1 from the first edge after release.
REQ-032 Reset mid-operation SHALL discard in-flight beats with no out_valid pulse.

Structure
REQ-033 Lane-mode encodings, lane width/count constants and MSB indices SHALL live in shared package simd_alu_pkg.
REQ-034 One sub-module simd_lane_sat (combinational clamp of one byte slot given mode, sign, flags) SHALL be instantiated per byte slot in S2.
REQ-035 Datapath SHALL be generated per lane size from SIMD_DATA_WIDTH with no hard-coded 256.

Verification
REQ-036 8b unsigned add, a bytes=0xF0, b bytes=0x20, saturate=0 -> result bytes 0x10, all ovf=1, udf=0, out_valid 2 cycles after accept.
REQ-037 16b signed sub, lane a=0x8000, b=0x0001, saturate=1 -> lane 0x8000, udf=1 on both byte slots; saturate=0 -> 0x7FFF, udf=1.
REQ-038 64b unsigned add, a=all-ones, b=1, saturate=1 -> every lane all-ones, ovf=0xFFFFFFFF; evt_cnt increments by 1.
REQ-039 Back-to-back 8 beats with out_ready toggled 1,0,0,1... -> all 8 results in order, stable during stall, in_ready=0 only when both stages full and out_ready=0.
REQ-040 Assert rst_n low with two beats in flight -> out_valid=0 immediately, evt_cnt=0, no stale beat after release.
REQ-041 evt_cnt at all-ones plus flagged beat -> stays all-ones; evt_clr coincident with flagged beat -> 0.
